// File: rtl/fir_pkg.sv
// Shared constants, symbol codes and arithmetic helpers for the 40-tap
// PAM-4 interpolation FIR.
package fir_pkg;

   localparam int N_TAP      = 40;
   localparam int N_BANK     = 4;
   localparam int BANK_LEN   = 10;
   localparam int COEF_W     = 16;
   localparam int ACC_W      = 24;
   localparam int BANK_ACC_W = 22;
   localparam int SYM_W      = 3;
   localparam int PROD_W     = COEF_W + SYM_W;

   localparam logic [2:0] SYM_P1 = 3'b001;
   localparam logic [2:0] SYM_P3 = 3'b011;
   localparam logic [2:0] SYM_M1 = 3'b111;
   localparam logic [2:0] SYM_M3 = 3'b101;

   function automatic logic signed [SYM_W-1:0] decodeSym(input logic [2:0] code);
      logic signed [SYM_W-1:0] val;
      case (code)
         SYM_P1:  val = 3'sd1;
         SYM_P3:  val = 3'sd3;
         SYM_M1:  val = -3'sd1;
         SYM_M3:  val = -3'sd3;
         default: val = 3'sd0;
      endcase
      return val;
   endfunction

   function automatic logic signed [COEF_W-1:0] satOut(input logic signed [ACC_W-1:0] sum);
      logic signed [COEF_W-1:0] res;
      if (sum > 24'sd32767) begin
         res = 16'sh7FFF;
      end else if (sum < -24'sd32768) begin
         res = 16'sh8000;
      end else begin
         res = sum[COEF_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_mac_bank.sv
// One 10-tap bank: coefficient register file, tap slice multiplexer and a
// 22-bit multiply-accumulator stepped by the shared slot counter.
module fir_mac_bank
   import fir_pkg::*;
(
   input  logic                          iClk12M,
   input  logic                          iRst,
   input  logic                          wrEn,
   input  logic [3:0]                    wrSlot,
   input  logic [COEF_W-1:0]             wrData,
   input  logic [BANK_LEN*SYM_W-1:0]     taps,
   input  logic                          clrAcc,
   input  logic                          macEn,
   input  logic [3:0]                    slot,
   output logic signed [BANK_ACC_W-1:0]  accOut
);

   logic signed [COEF_W-1:0]     coef_r [BANK_LEN];
   logic signed [COEF_W-1:0]     coef_s;
   logic signed [SYM_W-1:0]      tap_s;
   logic signed [PROD_W-1:0]     prod_s;
   logic signed [BANK_ACC_W-1:0] acc_r;

   // Coefficient storage; slot codes 10..15 are unmapped and dropped.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         for (int i = 0; i < BANK_LEN; i++) begin
            coef_r[i] <= '0;
         end
      end else if (wrEn && (wrSlot < 4'd10)) begin
         coef_r[wrSlot] <= wrData;
      end
   end

   // Select the coefficient and tap for the current slot.
   always_comb begin
      coef_s = '0;
      tap_s  = '0;
      if (slot < 4'd10) begin
         coef_s = coef_r[slot];
         tap_s  = taps[SYM_W*int'(slot) +: SYM_W];
      end else begin
         coef_s = '0;
         tap_s  = '0;
      end
   end

   assign prod_s = PROD_W'(coef_s) * PROD_W'(tap_s);

   // Accumulator cleared at the start of each sample computation.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         acc_r <= '0;
      end else if (clrAcc) begin
         acc_r <= '0;
      end else if (macEn) begin
         acc_r <= acc_r + BANK_ACC_W'(prod_s);
      end
   end

   assign accOut = acc_r;

endmodule

// File: rtl/top_fir_filter_flex.sv
// 40-tap programmable FIR: delay line, sequencing FSM, four parallel bank
// MACs, final adder and output saturation.
module top_fir_filter_flex
   import fir_pkg::*;
(
   input  logic        iClk12M,
   input  logic        iRst,
   input  logic        iEnSample600k,
   input  logic        iCoeffUpdateFlag,
   input  logic        iCsnRam,
   input  logic        iWrnRam,
   input  logic [5:0]  iAddrRam,
   input  logic [15:0] iWrDtRam,
   input  logic [2:0]  iFirIn,
   output logic [15:0] oFirOut
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHIFT = 3'd1;
   localparam logic [2:0] ST_MAC   = 3'd2;
   localparam logic [2:0] ST_SUM   = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   logic [2:0]                    state_r;
   logic [3:0]                    slot_r;
   logic [N_TAP*SYM_W-1:0]        delay_r;
   logic [SYM_W-1:0]              newSym_r;
   logic signed [ACC_W-1:0]       sum_r;
   logic signed [COEF_W-1:0]      firOut_r;
   logic signed [ACC_W-1:0]       bankSum_s;
   logic signed [BANK_ACC_W-1:0]  bankAcc_s [N_BANK];
   logic                          wrAny_s;
   logic                          clrAcc_s;
   logic                          macEn_s;

   assign wrAny_s  = iCoeffUpdateFlag & ~iCsnRam & ~iWrnRam;
   assign clrAcc_s = (state_r == ST_SHIFT);
   assign macEn_s  = (state_r == ST_MAC);

   for (genvar b = 0; b < N_BANK; b++) begin : g_bank
      fir_mac_bank u_bank (
         .iClk12M (iClk12M),
         .iRst    (iRst),
         .wrEn    (wrAny_s && (iAddrRam[5:4] == 2'(b))),
         .wrSlot  (iAddrRam[3:0]),
         .wrData  (iWrDtRam),
         .taps    (delay_r[b*BANK_LEN*SYM_W +: BANK_LEN*SYM_W]),
         .clrAcc  (clrAcc_s),
         .macEn   (macEn_s),
         .slot    (slot_r),
         .accOut  (bankAcc_s[b])
      );
   end

   // Adder tree over the sign-extended bank results.
   always_comb begin
      bankSum_s = '0;
      for (int b = 0; b < N_BANK; b++) begin
         bankSum_s = bankSum_s + ACC_W'(bankAcc_s[b]);
      end
   end

   // Sequencer; the symbol is captured on the strobe so iFirIn need not be held.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         state_r  <= ST_IDLE;
         slot_r   <= 4'd0;
         delay_r  <= '0;
         newSym_r <= 3'd0;
         sum_r    <= '0;
         firOut_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (iEnSample600k && !iCoeffUpdateFlag) begin
                  newSym_r <= decodeSym(iFirIn);
                  state_r  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               delay_r <= {delay_r[(N_TAP-1)*SYM_W-1:0], newSym_r};
               slot_r  <= 4'd0;
               state_r <= ST_MAC;
            end
            ST_MAC: begin
               if (slot_r == 4'(BANK_LEN-1)) begin
                  state_r <= ST_SUM;
               end else begin
                  slot_r <= slot_r + 4'd1;
               end
            end
            ST_SUM: begin
               sum_r   <= bankSum_s;
               state_r <= ST_OUT;
            end
            ST_OUT: begin
               firOut_r <= satOut(sum_r);
               state_r  <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign oFirOut = firOut_r;

endmodule

// File: tb/tb_top_fir_filter_flex.sv
// Scoreboard bench: the driver pushes reference-model outputs into a queue,
// the monitor pops and compares 13 clocks after every accepted strobe.
module tb_top_fir_filter_flex;

   logic        iClk12M = 1'b0;
   logic        iRst;
   logic        iEnSample600k;
   logic        iCoeffUpdateFlag;
   logic        iCsnRam;
   logic        iWrnRam;
   logic [5:0]  iAddrRam;
   logic [15:0] iWrDtRam;
   logic [2:0]  iFirIn;
   logic [15:0] oFirOut;

   int checks = 0;
   int errors = 0;
   int expQ[$];
   int hist[$];
   int coefM[40];
   int lastOut = 0;
   int table0[40];

   top_fir_filter_flex dut (
      .iClk12M          (iClk12M),
      .iRst             (iRst),
      .iEnSample600k    (iEnSample600k),
      .iCoeffUpdateFlag (iCoeffUpdateFlag),
      .iCsnRam          (iCsnRam),
      .iWrnRam          (iWrnRam),
      .iAddrRam         (iAddrRam),
      .iWrDtRam         (iWrDtRam),
      .iFirIn           (iFirIn),
      .oFirOut          (oFirOut)
   );

   always #5 iClk12M = ~iClk12M;

   function automatic int decodeRef(input logic [2:0] c);
      case (c)
         3'b001:  return 1;
         3'b011:  return 3;
         3'b111:  return -1;
         3'b101:  return -3;
         default: return 0;
      endcase
   endfunction

   function automatic int refOut();
      longint s = 0;
      for (int k = 0; k < 40; k++) s += longint'(coefM[k]) * longint'(hist[k]);
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return int'(s);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      hist.delete();
      for (int k = 0; k < 40; k++) begin
         hist.push_back(0);
         coefM[k] = 0;
      end
      lastOut = 0;
   endtask

   task automatic writeCoef(input logic [5:0] addr, input logic [15:0] data, input logic flag);
      @(negedge iClk12M);
      iCoeffUpdateFlag = flag;
      iAddrRam = addr; iWrDtRam = data; iCsnRam = 1'b0; iWrnRam = 1'b0;
      if (flag && addr[3:0] < 4'd10) coefM[int'(addr[5:4])*10 + int'(addr[3:0])] = int'($signed(data));
      @(negedge iClk12M);
      iCsnRam = 1'b1; iWrnRam = 1'b1;
   endtask

   // One 20-clock sample period; optionally raises the load flag mid-computation.
   task automatic sendSample(input logic [2:0] sym, input bit midFlag);
      @(negedge iClk12M);
      iFirIn = sym; iEnSample600k = 1'b1;
      if (!iCoeffUpdateFlag) begin
         hist.push_front(decodeRef(sym));
         void'(hist.pop_back());
         expQ.push_back(refOut());
      end
      @(negedge iClk12M);
      iEnSample600k = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(negedge iClk12M);
         if (midFlag && i == 3) iCoeffUpdateFlag = 1'b1;
      end
   endtask

   // Write and strobe in the same cycle while in load mode.
   task automatic writeWithStrobe(input logic [5:0] addr, input logic [15:0] data);
      @(negedge iClk12M);
      iAddrRam = addr; iWrDtRam = data; iCsnRam = 1'b0; iWrnRam = 1'b0;
      iEnSample600k = 1'b1; iFirIn = 3'b011;
      if (addr[3:0] < 4'd10) coefM[int'(addr[5:4])*10 + int'(addr[3:0])] = int'($signed(data));
      @(negedge iClk12M);
      iCsnRam = 1'b1; iWrnRam = 1'b1; iEnSample600k = 1'b0;
      repeat (18) @(negedge iClk12M);
   endtask

   task automatic impulse(input logic [2:0] sym);
      sendSample(sym, 1'b0);
      for (int i = 0; i < 39; i++) sendSample(3'b000, 1'b0);
   endtask

   // Monitor: output must hold through clock 12 and update at clock 13.
   initial begin
      int exp;
      forever begin
         @(posedge iClk12M);
         if (iEnSample600k && !iCoeffUpdateFlag && !iRst) begin
            repeat (12) @(posedge iClk12M);
            #1;
            check("latencyHold", int'($signed(oFirOut)), lastOut);
            @(posedge iClk12M);
            #1;
            if (expQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpectedOutput actual=%0d expected=none", $signed(oFirOut));
            end else begin
               exp = expQ.pop_front();
               check("firOut", int'($signed(oFirOut)), exp);
               lastOut = exp;
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] sym;
      int base[17] = '{146, 0, -242, 302, 0, -520, 612, 0, -1100, 1300, 0,
                       -2400, 3000, 0, -5200, 8993, 21845};
      for (int k = 0; k < 40; k++) table0[k] = 0;
      for (int k = 0; k <= 16; k++) begin
         table0[k] = base[k];
         table0[32-k] = base[k];
      end

      iRst = 1'b1; iEnSample600k = 1'b0; iCoeffUpdateFlag = 1'b0;
      iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = 6'd0; iWrDtRam = 16'd0; iFirIn = 3'd0;
      resetModel();
      repeat (5) @(negedge iClk12M);
      iRst = 1'b0;
      #1;
      check("resetOut", int'($signed(oFirOut)), 0);

      // Zero coefficients, random input
      for (int i = 0; i < 20; i++) sendSample(3'($urandom_range(0, 7)), 1'b0);

      // Load impulse table
      for (int k = 0; k < 40; k++)
         writeCoef({2'(k / 10), 4'(k % 10)}, 16'(table0[k]), 1'b1);
      iCoeffUpdateFlag = 1'b0;
      for (int i = 0; i < 40; i++) sendSample(3'b000, 1'b0);
      impulse(3'b001);
      impulse(3'b101);

      // Unmapped slots and flag-low writes must not alter the table
      for (int b = 0; b < 4; b++)
         for (int s = 10; s < 16; s++)
            writeCoef({2'(b), 4'(s)}, 16'h7FFF, 1'b1);
      writeCoef(6'd0, 16'h1234, 1'b0);
      writeCoef(6'h25, 16'h1234, 1'b0);
      impulse(3'b001);

      // Random PAM-4 at 200 kHz with load-mode pauses
      for (int i = 0; i < 500; i++) begin
         bit mid;
         sym = 3'($urandom_range(0, 7));
         mid = ((i % 50) == 25);
         sendSample(sym, mid);
         if (mid) begin
            #1;
            check("loadHold", int'($signed(oFirOut)), lastOut);
            sendSample(3'($urandom_range(0, 7)), 1'b0);
            writeCoef(6'($urandom_range(0, 63)), 16'($urandom()), 1'b1);
            writeWithStrobe(6'($urandom_range(0, 63)), 16'($urandom()));
            #1;
            check("loadHold", int'($signed(oFirOut)), lastOut);
            @(negedge iClk12M);
            iCoeffUpdateFlag = 1'b0;
         end
         sendSample(3'b000, 1'b0);
         sendSample(3'b000, 1'b0);
      end

      for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge iClk12M);
      check("drain", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/top_fir_filter_flex.md
# top_fir_filter_flex

Programmable 40-tap FIR interpolation filter for a 4-level (PAM-4) symbol stream, clocked at 12 MHz and fed at a 600 kHz sample strobe. Sixteen-bit coefficients are loaded through a simple SRAM-style write port organised as four 10-coefficient banks. Four bank MACs run in parallel over the 20 system clocks available per sample. The block sits between the symbol mapper/upsampler and the DAC path.

## Interface
- No parameters. Widths are fixed by package constants.
- `iClk12M` in 1: 12 MHz system clock; all logic on rising edge.
- `iRst` in 1: synchronous, active-high reset.
- `iEnSample600k` in 1: one-clock sample strobe, 1 in every 20 clocks.
- `iCoeffUpdateFlag` in 1: 1 = coefficient-load mode, 0 = filter run mode.
- `iCsnRam` in 1: coefficient RAM chip select, active low.
- `iWrnRam` in 1: coefficient RAM write enable, active low.
- `iAddrRam` in 6: coefficient address. [5:4] = bank 0..3; [3:0] = slot 0..9.
- `iWrDtRam` in 16: coefficient write data, two's complement.
- `iFirIn` in 3: input symbol code.
- `oFirOut` out 16: filtered sample, signed, registered.

## Operation
- Symbol decode:
  - 001 = +1, 011 = +3, 111 = −1, 101 = −3.
  - 000 and any other code = 0.
- Coefficient k = bank·10 + slot, for k = 0..39.
- Coefficient write: a write occurs on a rising edge when iCoeffUpdateFlag=1, iCsnRam=0 and iWrnRam=0.
  - The word at iAddrRam is written with iWrDtRam.
  - Slot values 10..15 are ignored (no write).
  - Writes with iCoeffUpdateFlag=0 are ignored.
- Delay line: 40 × 3-bit decoded samples x[0..39].
  - On iEnSample600k with flag=0, shift: x[0] ← decoded iFirIn, x[i] ← x[i−1].
- Computation: y = Σ c[k]·x[k] for k = 0..39, with x[0] the newest sample.
  - Each bank MAC handles 10 taps over 10 clocks.
  - The bank results are then summed.
- Arithmetic:
  - Product is 16b × 3b signed.
  - Bank accumulators are 22-bit signed.
  - Final sum is 24-bit signed.
  - oFirOut is the sum saturated to [−32768, 32767], with no scaling.
- Load mode (flag=1):
  - Delay line frozen.
  - MAC idle.
  - oFirOut holds its last value.
- Reset:
  - All coefficients = 0.
  - Delay line = 0.
  - Accumulators = 0.
  - MAC FSM returns to IDLE.
  - oFirOut = 0.
  - Reset mid-computation aborts the computation.

## Timing
- MAC FSM states: IDLE → SHIFT → MAC → SUM → OUT → IDLE.
  - IDLE: wait for iEnSample600k with flag=0.
  - SHIFT (1 clock): shift the delay line, clear the accumulators.
  - MAC (10 clocks, slot counter 0..9): each bank accumulates c[bank·10+slot]·x[bank·10+slot].
  - SUM (1 clock): add the four bank results.
  - OUT (1 clock): saturate and register oFirOut.
- Latency: oFirOut is updated 13 clocks after the strobe edge.
- oFirOut then stays stable for ≥7 clocks before the next strobe.
- A strobe arriving while the FSM is busy is ignored; it cannot occur with a 20-clock period.
- Flag rising during MAC: the current computation completes; a new one does not start while flag=1.
- Write and strobe in the same cycle: the write proceeds and the strobe is ignored (load mode).

## Structure
- Package `fir_pkg`:
  - constants N_TAP=40, N_BANK=4, BANK_LEN=10, COEF_W=16, ACC_W=24;
  - symbol code localparams;
  - a decode function returning a 3-bit signed value.
- Sub-module `fir_mac_bank`, instantiated 4×. Each contains:
  - a 10×16 coefficient register file with write decode;
  - the 10-tap slice multiplexer;
  - a 22-bit accumulator.
- The top level contains the delay line, the FSM/slot counter, the adder tree and the saturation logic.

## Test plan
- Reset: hold iRst 5 clocks → oFirOut=0. With all coefficients 0 and random input, oFirOut stays 0.
- Impulse: load c[k] for k=0..32 (146, 0, −242, 302, …, 21845 at k=16, …, 146), remaining taps 0. Input 001 once, then 000 → successive outputs c[0], c[1], …, c[32], then 0 × 7.
- Negative/×3 impulse: input 101 (−3) once → outputs −3·c[k]. At k=16, −65535 saturates to −32768. At k=15 the output is −26979.
- Address gaps: write addresses 10..15 with data 0x7FFF, then run an impulse → no change versus the loaded table. A write with flag=0 has no effect.
- Random PAM-4: load the table, feed 500 random symbols at 200 kHz (symbol then 000, 000) → each oFirOut equals the saturated reference model sum.
- Load mid-run: assert flag between strobes → oFirOut held and delay line frozen. On release, filtering resumes from the preserved history.
